// File: rtl/pdp8_tty_iot.sv
// PDP-8 console teletype: keyboard (device 03) and teleprinter (device 04) on the IOT bus.
// Define TTY_INTERRUPT_EN to add the irq output, the ie bit and the 6035 KIE instruction.
module pdp8_tty_iot #(
  parameter int         PRINT_CYCLES = 16,
  parameter logic [5:0] KBD_DEV      = 6'o03,
  parameter logic [5:0] TTY_DEV      = 6'o04
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        iot_valid,
  input  logic [11:0] iot_ir,
  input  logic [11:0] iot_ac,
  output logic        iot_ack,
  output logic        iot_skip,
  output logic        iot_clr_ac,
  output logic        iot_or_ac,
  output logic [7:0]  iot_datain,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tty_busy,
`ifdef TTY_INTERRUPT_EN
  output logic        irq,
`endif
  output logic [1:0]  tty_state
);

  localparam int CW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_DELAY = 2'd1,
    T_SEND  = 2'd2
  } tty_state_t;

  tty_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          kbd_flag, tty_flag;
  logic [7:0]    kbd_buf, tx_buf;

  logic [2:0] fn;
  logic       is_iot, kbd_sel, tty_sel, kie, kbd_op;
  logic       kbd_clr, rx_fire, tx_fire, print_req, print_start;
  logic       unused_ac_bits;

  assign fn      = iot_ir[2:0];
  assign is_iot  = iot_valid && (iot_ir[11:9] == 3'b110);
  assign kbd_sel = is_iot && (iot_ir[8:3] == KBD_DEV);
  assign tty_sel = is_iot && (iot_ir[8:3] == TTY_DEV);
`ifdef TTY_INTERRUPT_EN
  assign kie = kbd_sel && (fn == 3'b101);
`else
  assign kie = 1'b0;
`endif
  assign kbd_op = kbd_sel && !kie;

  // Valid/ready: a byte moves on any rising edge where valid and ready are both high;
  // the sender holds valid and data stable until then, and ready never depends on valid.
  assign rx_ready = ~kbd_flag;
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_valid = (state == T_SEND);
  assign tx_data  = tx_buf;
  assign tx_fire  = tx_valid && tx_ready;
  assign tty_busy = (state != T_IDLE);
  assign tty_state = state;

  // KCF (function 000) clears the flag just like the explicit clear bit does.
  assign kbd_clr     = kbd_op && ((fn == 3'b000) || fn[1]);
  assign print_req   = tty_sel && fn[2];
  assign print_start = print_req && (state == T_IDLE);
  assign unused_ac_bits = ^iot_ac[11:8];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      iot_ack    <= 1'b0;
      iot_skip   <= 1'b0;
      iot_clr_ac <= 1'b0;
      iot_or_ac  <= 1'b0;
      iot_datain <= 8'h00;
    end else begin
      iot_ack    <= kbd_sel || tty_sel;
      iot_skip   <= (kbd_op && fn[0] && kbd_flag) || (tty_sel && fn[0] && tty_flag);
      iot_clr_ac <= kbd_op && fn[1];
      iot_or_ac  <= kbd_op && fn[2];
      iot_datain <= (kbd_op && fn[2]) ? kbd_buf : 8'h00;
    end
  end

  // A keystroke arriving alongside a flag clear wins, so it is never lost.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      kbd_flag <= 1'b0;
      kbd_buf  <= 8'h00;
    end else if (rx_fire) begin
      kbd_flag <= 1'b1;
      kbd_buf  <= rx_data;
    end else if (kbd_clr) begin
      kbd_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      tty_flag <= 1'b0;
      tx_buf   <= 8'h00;
    end else begin
      if (tx_fire || (tty_sel && (fn == 3'b000))) tty_flag <= 1'b1;
      else if (tty_sel && fn[1])                  tty_flag <= 1'b0;
      if (print_start) tx_buf <= iot_ac[7:0];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= T_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      T_IDLE: if (print_req) begin
        state_nx = T_DELAY;
        cnt_nx   = CW'(PRINT_CYCLES - 1);
      end
      T_DELAY: begin
        if (cnt == '0) state_nx = T_SEND;
        else           cnt_nx   = cnt - CW'(1);
      end
      T_SEND: if (tx_ready) state_nx = T_IDLE;
      default: state_nx = T_IDLE;
    endcase
  end

`ifdef TTY_INTERRUPT_EN
  logic ie;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ie  <= 1'b1;
      irq <= 1'b0;
    end else begin
      if (kie) ie <= iot_ac[0];
      irq <= ie && (kbd_flag || tty_flag);
    end
  end
`endif

endmodule

// File: tb/tb_pdp8_tty_iot.sv
// Directed plus randomized bench for pdp8_tty_iot against a flag/queue level reference model.
module tb_pdp8_tty_iot;
  localparam int PC = 16;

  logic        clock = 1'b0;
  logic        resetN;
  logic        iot_valid;
  logic [11:0] iot_ir, iot_ac;
  logic        iot_ack, iot_skip, iot_clr_ac, iot_or_ac;
  logic [7:0]  iot_datain;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tty_busy;
  logic [1:0]  tty_state;
`ifdef TTY_INTERRUPT_EN
  logic        irq;
`endif

  pdp8_tty_iot #(.PRINT_CYCLES(PC)) dut (
    .clock(clock), .resetN(resetN),
    .iot_valid(iot_valid), .iot_ir(iot_ir), .iot_ac(iot_ac),
    .iot_ack(iot_ack), .iot_skip(iot_skip), .iot_clr_ac(iot_clr_ac),
    .iot_or_ac(iot_or_ac), .iot_datain(iot_datain),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tty_busy(tty_busy),
`ifdef TTY_INTERRUPT_EN
    .irq(irq),
`endif
    .tty_state(tty_state)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: flags, keyboard byte, pending print queue with due cycle
  bit         m_kflag, m_tflag, m_busy;
  logic [7:0] m_kbuf;
  int         m_due;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    #1;
    check("rst_ack", iot_ack, 0);
    check("rst_skip", iot_skip, 0);
    check("rst_clr", iot_clr_ac, 0);
    check("rst_or", iot_or_ac, 0);
    check("rst_datain", iot_datain, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", tty_busy, 0);
    check("rst_rx_ready", rx_ready, 1);
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    m_kflag = 0; m_tflag = 0; m_busy = 0; m_kbuf = 8'h00;
    exp_q.delete();
  endtask

  // drive one cycle of IOT (and optional keystroke), then check the registered response
  task automatic iot(input logic [11:0] ir, input logic [11:0] ac, input bit rxv, input logic [7:0] rxd);
    logic [2:0] fn;
    bit kbd, tty, e_ack, e_skip, e_clr, e_or, rx_acc;
    logic [7:0] e_din;
    fn     = ir[2:0];
    kbd    = (ir[11:9] == 3'b110) && (ir[8:3] == 6'o03);
    tty    = (ir[11:9] == 3'b110) && (ir[8:3] == 6'o04);
    e_ack  = kbd || tty;
    e_skip = (kbd && fn[0] && m_kflag) || (tty && fn[0] && m_tflag);
    e_clr  = kbd && fn[1];
    e_or   = kbd && fn[2];
    e_din  = e_or ? m_kbuf : 8'h00;
    rx_acc = rxv && !m_kflag;
    iot_valid = 1'b1; iot_ir = ir; iot_ac = ac;
    rx_valid = rxv; rx_data = rxd;
    @(negedge clock);
    iot_valid = 1'b0; rx_valid = 1'b0;
    if (kbd && (fn == 3'b000 || fn[1])) m_kflag = 0;
    if (rx_acc) begin m_kflag = 1; m_kbuf = rxd; end
    if (tty && fn == 3'b000) m_tflag = 1;
    if (tty && fn[1]) m_tflag = 0;
    if (tty && fn[2] && !m_busy) begin
      m_busy = 1; m_due = cyc + PC; exp_q.push_back(ac[7:0]);
    end
    check("ack", iot_ack, e_ack);
    check("skip", iot_skip, e_skip);
    check("clr_ac", iot_clr_ac, e_clr);
    check("or_ac", iot_or_ac, e_or);
    check("datain", iot_datain, e_din);
    check("rx_ready", rx_ready, !m_kflag);
    check("tty_busy", tty_busy, m_busy);
  endtask

  // wait for the pending character, hold off the sink for wait_n cycles, then accept it
  task automatic drain(input int wait_n);
    logic [7:0] e;
    e = exp_q.pop_front();
    while (cyc < m_due) begin
      if (cyc == m_due - 1) check("tx_early", tx_valid, 0);
      @(negedge clock);
    end
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, e);
    repeat (wait_n) begin
      @(negedge clock);
      check("tx_hold_valid", tx_valid, 1);
      check("tx_hold_data", tx_data, e);
    end
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    m_busy = 0; m_tflag = 1;
    check("tx_done", tx_valid, 0);
    check("busy_done", tty_busy, 0);
  endtask

  initial begin
    logic [2:0] fn;
    logic [5:0] dev;
    resetN = 1'b1; iot_valid = 1'b0; iot_ir = '0; iot_ac = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    do_reset();

    // reset mid-print discards the character
    iot(12'o6046, 12'o0101, 0, 8'h00);
    repeat (10) @(negedge clock);
    check("midprint_busy", tty_busy, 1);
    do_reset();
    repeat (30) begin
      @(negedge clock);
      check("midprint_no_tx", tx_valid, 0);
    end
    iot(12'o6041, 12'o0000, 0, 8'h00);

    // print with delayed acceptance, then TSF
    iot(12'o6046, 12'o0101, 0, 8'h00);
    @(negedge clock);
    check("ack_one_cycle", iot_ack, 0);
    drain(3);
    iot(12'o6041, 12'o0000, 0, 8'h00);

    // keyboard receive, KSF, KRB, KSF
    iot(12'o0000, 12'o0000, 1, 8'h5A);
    iot(12'o6031, 12'o0000, 0, 8'h00);
    iot(12'o6036, 12'o0000, 0, 8'h00);
    iot(12'o6031, 12'o0000, 0, 8'h00);

    // print while busy is ignored
    iot(12'o6044, 12'h031, 0, 8'h00);
    repeat (4) @(negedge clock);
    iot(12'o6044, 12'h032, 0, 8'h00);
    drain(1);
    repeat (20) begin
      @(negedge clock);
      check("busy_print_dropped", tx_valid, 0);
    end

    // KCC colliding with a keystroke
    iot(12'o6030, 12'o0000, 0, 8'h00);
    iot(12'o6032, 12'o0000, 1, 8'h0D);
    iot(12'o6034, 12'o0000, 0, 8'h00);
    iot(12'o6031, 12'o0000, 0, 8'h00);
    iot(12'o6036, 12'o0000, 0, 8'h00);

    // foreign device
    iot(12'o6051, 12'o7777, 0, 8'h00);

    // randomized mix
    repeat (80) begin
      fn = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin
          dev = 6'($urandom_range(0, 63));
          if (dev == 6'o03 || dev == 6'o04) dev = 6'o05;
          iot({3'b110, dev, fn}, 12'($urandom), 1'($urandom), 8'($urandom));
        end
        1: begin
`ifdef TTY_INTERRUPT_EN
          if (fn == 3'b101) fn = 3'b100;
`endif
          iot({6'o60, 3'b011, fn}, 12'($urandom), 1'($urandom), 8'($urandom));
        end
        2: iot({6'o60, 3'b100, 1'b0, fn[1:0]}, 12'($urandom), 1'($urandom), 8'($urandom));
        default: begin
          iot({6'o60, 3'b100, 1'b1, fn[1], 1'b0}, 12'($urandom), 0, 8'h00);
          drain($urandom_range(0, 5));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdp8_tty_iot.md
Name: pdp8_tty_iot

Overview:
Console teletype device for the PDP-8 IOT bus. It sits on the far side of the CPU's IOT distributor from the CPU. It decodes keyboard (device 03) and teleprinter (device 04) IOT instructions and returns skip, clear-AC and OR-datain responses to the controller. It buffers one received character from a host byte source and drives printed characters to a host byte sink after a modelled print delay.

Parameters:
PRINT_CYCLES, 16, clocks the teleprinter stays busy after a load before presenting the character (minimum 1)
KBD_DEV, 6'o03, keyboard device code matched against IR[8:3]
TTY_DEV, 6'o04, teleprinter device code matched against IR[8:3]

Ports:
clock  input  1  system clock; all state changes on rising edge
resetN  input  1  asynchronous active-low reset
iot_valid  input  1  one-cycle strobe: CPU is executing an IOT
iot_ir  input  12  instruction register; IOT when IR[11:9]=3'b110
iot_ac  input  12  current accumulator; TLS/TPC print data = iot_ac[7:0]
iot_ack  output  1  registered pulse: addressed device handled the IOT
iot_skip  output  1  registered: CPU must skip next instruction
iot_clr_ac  output  1  registered: CPU clears AC
iot_or_ac  output  1  registered: CPU ORs {4'h0,iot_datain} into AC (after clear, if both)
iot_datain  output  8  keyboard buffer, valid when iot_or_ac=1, else 0
rx_valid  input  1  host keystroke available
rx_data  input  8  host keystroke
rx_ready  output  1  device can accept a keystroke (= ~kbd_flag)
tx_valid  output  1  printed character available to host
tx_data  output  8  printed character
tx_ready  input  1  host accepts character
tty_busy  output  1  teleprinter state != T_IDLE

Behaviour:
- Reset (async, resetN=0): kbd_flag=0, kbd_buf=0, tty_flag=0, tx_buf=0, state T_IDLE, counter 0; iot_ack/skip/clr_ac/or_ac=0, iot_datain=0, tx_valid=0, tx_data=0, tty_busy=0, rx_ready=1. A reset during print discards the character.
- Decode when iot_valid & IR[11:9]=110 & IR[8:3] in {KBD_DEV,TTY_DEV}. Other devices: no response, outputs stay 0. Responses register one clock after iot_valid and last exactly one cycle.
- Function bits: IR[0] = skip if flag, IR[1] = clear flag, IR[2] = read/print.
- Skip tests the flag value before this instruction's own clear.
- Keyboard: 6030 KCF clears flag. 6031 KSF skips on kbd_flag. 6032 KCC clears flag and sets clr_ac. 6034 KRS sets or_ac with datain=kbd_buf. 6036 KRB does KCC plus KRS.
- Teleprinter: 6040 SPF sets tty_flag. 6041 TSF skips on tty_flag. 6042 TCF clears the flag. 6044 TPC loads tx_buf from iot_ac[7:0] and starts a print. 6046 TLS does TCF plus TPC.
- Teleprinter FSM:
  - T_IDLE: on print, go to T_DELAY with counter=PRINT_CYCLES-1.
  - T_DELAY: decrement each cycle; at 0 go to T_SEND.
  - T_SEND: tx_valid=1 and tx_data=tx_buf, held stable until tx_valid&tx_ready. On handshake set tty_flag and return to T_IDLE.
- A print issued while tty_busy is ignored: the buffer and FSM are unchanged, but TLS still clears the flag.
- Keyboard receive: rx_valid&rx_ready loads kbd_buf<=rx_data and sets kbd_flag. If a flag-clear IOT and a receive occur in the same cycle, the receive wins and the flag is set.
- Flags change on the clock after iot_valid, together with the response.

Optional Feature:
TTY_INTERRUPT_EN.
- With the macro defined: adds output irq (1 bit) and an interrupt-enable bit ie, reset to 1. 6035 KIE loads ie<=iot_ac[0] and acks with no skip. irq = ie & (kbd_flag | tty_flag), registered.
- Without the macro: no irq port, no ie bit, and 6035 behaves as KSF+KRS (skip and OR) per the function bits.

Test Plan:
- Reset mid-print: TLS with AC=12'o0101, then resetN=0 at counter 5 -> tx_valid stays 0, tty_busy=0, tty_flag=0, no character is ever sent.
- Print: TLS with AC=12'o0101 -> iot_ack=1 next cycle, no skip; tx_valid rises after 16 cycles with tx_data=8'h41; tx_ready after 3 cycles of wait -> tty_flag=1; then TSF -> iot_skip=1.
- Keyboard: rx_valid with rx_data=8'h5A -> rx_ready=0; KSF -> skip=1; KRB -> clr_ac=1, or_ac=1, datain=8'h5A; next cycle rx_ready=1; second KSF -> skip=0.
- Busy print: TPC with AC=8'h31, then TPC with AC=8'h32 at delay cycle 4 -> only 8'h31 is transmitted.
- Collision: kbd_flag=0 while KCC and rx_valid (8'h0D) occur in the same cycle -> kbd_flag=1, kbd_buf=8'h0D, clr_ac=1.
- Foreign device: IOT 6xx with IR=12'o6051 -> iot_ack=0 and all response outputs remain 0.
